// File: rtl/chip8_mem_arbiter.sv
//==============================================================================
// chip8_mem_arbiter: shares the 4 KiB CHIP-8 RAM between video, CPU and PPU,
// with a time-bounded PPU lock for sprite read-modify-write.
// Revision: 1.0
//==============================================================================
`default_nettype none

module chip8_mem_arbiter #(
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [11:0] vid_addr,
    output logic        vid_gnt,
    output logic        vid_rvalid,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        ppu_req,
    input  logic        ppu_we,
    input  logic [11:0] ppu_addr,
    input  logic [7:0]  ppu_wdata,
    input  logic        ppu_lock,
    output logic        ppu_gnt,
    output logic        ppu_rvalid,
    output logic [7:0]  rd_data,
    output logic        ram_en,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        lock_err
);

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t state;
    logic [7:0]  lock_cnt;
    logic        last_cpu;     // 0: CPU holds the last-served slot, so the PPU wins the first tie
    logic        ignore_lock;  // set by a forced unlock until ppu_lock is seen low

    always_comb begin
        vid_gnt = 1'b0;
        cpu_gnt = 1'b0;
        ppu_gnt = 1'b0;
        if (!reset) begin
            if (vid_req) begin
                vid_gnt = 1'b1;
            end else if (state == LOCKED) begin
                ppu_gnt = ppu_req;
            end else if (cpu_req && ppu_req) begin
                cpu_gnt = last_cpu;
                ppu_gnt = ~last_cpu;
            end else begin
                cpu_gnt = cpu_req;
                ppu_gnt = ppu_req;
            end
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 12'h000;
        ram_wdata = 8'h00;
        if (vid_gnt) begin
            ram_en   = 1'b1;
            ram_addr = vid_addr;
        end else if (cpu_gnt) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (ppu_gnt) begin
            ram_en    = 1'b1;
            ram_we    = ppu_we;
            ram_addr  = ppu_addr;
            ram_wdata = ppu_wdata;
        end
    end

    assign rd_data = ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= UNLOCKED;
            lock_cnt    <= 8'd0;
            last_cpu    <= 1'b0;
            ignore_lock <= 1'b0;
            lock_err    <= 1'b0;
            vid_rvalid  <= 1'b0;
            cpu_rvalid  <= 1'b0;
            ppu_rvalid  <= 1'b0;
        end else begin
            vid_rvalid <= vid_gnt;
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            ppu_rvalid <= ppu_gnt & ~ppu_we;

            if (cpu_gnt) begin
                last_cpu <= 1'b0;
            end else if (ppu_gnt) begin
                last_cpu <= 1'b1;
            end

            case (state)
                UNLOCKED: begin
                    if (ppu_gnt && ppu_lock && !ignore_lock) begin
                        state    <= LOCKED;
                        lock_cnt <= 8'd0;
                    end
                    if (!ppu_lock) begin
                        ignore_lock <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (!ppu_lock) begin
                        state <= UNLOCKED;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state       <= UNLOCKED;
                        lock_err    <= 1'b1;
                        ignore_lock <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end
                default: state <= UNLOCKED;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_chip8_mem_arbiter.sv
//==============================================================================
// tb_chip8_mem_arbiter: directed and random stimulus against a cycle model
// of the arbitration rules, with a behavioural RAM behind the DUT.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_chip8_mem_arbiter;

    localparam int LOCK_MAX = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, ppu_req = 1'b0, ppu_we = 1'b0, ppu_lock = 1'b0;
    logic [11:0] vid_addr = '0, cpu_addr = '0, ppu_addr = '0;
    logic [7:0]  cpu_wdata = '0, ppu_wdata = '0;
    logic        vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, ppu_gnt, ppu_rvalid;
    logic [7:0]  rd_data, ram_wdata;
    logic [7:0]  ram_rdata = '0;
    logic        ram_en, ram_we, lock_err;
    logic [11:0] ram_addr;

    chip8_mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
        .ppu_lock(ppu_lock), .ppu_gnt(ppu_gnt), .ppu_rvalid(ppu_rvalid),
        .rd_data(rd_data), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM macro behind the arbiter
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_err = 0;

    // Reference model: bit 2 = video, bit 1 = CPU, bit 0 = PPU
    bit       m_locked = 0, m_ignore = 0, m_err = 0, m_cpu_was_last = 1;
    int       m_age = 0;
    bit [2:0] m_rv = 0;
    bit [7:0] m_rdata = 0;
    bit [2:0] m_gnt;
    logic [2:0] obs_gnt;
    logic       obs_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit [2:0] model_grant();
        if (reset)                      return 3'b000;
        if (vid_req)                    return 3'b100;
        if (m_locked)                   return {2'b00, ppu_req};
        if (cpu_req && ppu_req)         return m_cpu_was_last ? 3'b001 : 3'b010;
        return {1'b0, cpu_req, ppu_req};
    endfunction

    // One clock cycle: inputs already applied at the falling edge
    task automatic step();
        bit        e_we;
        bit [11:0] e_addr;
        bit [7:0]  e_wd;
        bit [7:0]  next_rdata;
        #1;
        m_gnt = model_grant();
        e_we = 0; e_addr = 0; e_wd = 0;
        if (m_gnt[2])      begin e_addr = vid_addr; end
        else if (m_gnt[1]) begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
        else if (m_gnt[0]) begin e_we = ppu_we; e_addr = ppu_addr; e_wd = ppu_wdata; end
        next_rdata = mem[e_addr];
        obs_gnt = {vid_gnt, cpu_gnt, ppu_gnt};
        obs_err = lock_err;
        chk("gnt", 32'(obs_gnt), 32'(m_gnt));
        chk("ram_ctl", 32'({ram_en, ram_we}), 32'({|m_gnt, e_we}));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
        chk("rvalid", 32'({vid_rvalid, cpu_rvalid, ppu_rvalid}), 32'(m_rv));
        if (m_rv != 0) chk("rd_data", 32'(rd_data), 32'(m_rdata));
        chk("lock_err", 32'(obs_err), 32'(m_err));
        @(posedge clk);
        if (reset) begin
            m_locked = 0; m_age = 0; m_ignore = 0; m_err = 0; m_cpu_was_last = 1; m_rv = 0;
        end else begin
            m_rv = {m_gnt[2], m_gnt[1] & ~cpu_we, m_gnt[0] & ~ppu_we};
            m_rdata = next_rdata;
            if (m_gnt[1])      m_cpu_was_last = 1;
            else if (m_gnt[0]) m_cpu_was_last = 0;
            if (m_locked) begin
                m_age++;
                if (!ppu_lock) m_locked = 0;
                else if (m_age >= LOCK_MAX) begin
                    m_locked = 0; m_err = 1; m_ignore = 1;
                end
            end else begin
                if (m_gnt[0] && ppu_lock && !m_ignore) begin
                    m_locked = 1; m_age = 0;
                end
                if (!ppu_lock) m_ignore = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        vid_req = 0; cpu_req = 0; ppu_req = 0; ppu_lock = 0; cpu_we = 0; ppu_we = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h200] = 8'hA2;
        @(negedge clk);

        // Reset, then idle
        do_reset();
        step();
        chk("idle_gnt", 32'(obs_gnt), 32'd0);
        chk("idle_err", 32'(obs_err), 32'd0);

        // CPU read of 0x200
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h200;
        step();
        chk("cpu_rd_gnt", 32'(obs_gnt), 32'b010);
        cpu_req = 0;
        #1;
        chk("cpu_rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("cpu_rd_data", 32'(rd_data), 32'hA2);
        step();
        step();

        // All three requesting: video always wins
        vid_req = 1; cpu_req = 1; ppu_req = 1; cpu_addr = 12'h010; ppu_addr = 12'h020;
        for (int i = 0; i < 4; i++) begin
            vid_addr = 12'(12'h100 + i);
            step();
            chk("vid_priority", 32'(obs_gnt), 32'b100);
        end
        idle_inputs();
        step();

        // CPU/PPU round robin from reset: PPU, CPU, PPU, CPU
        do_reset();
        cpu_req = 1; ppu_req = 1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 12'(12'h040 + i); ppu_addr = 12'(12'h080 + i);
            step();
            chk("round_robin", 32'(obs_gnt), (i % 2 == 0) ? 32'b001 : 32'b010);
        end
        idle_inputs();
        step();

        // Locked read-modify-write of 0x108 with the CPU waiting
        cpu_req = 1; cpu_addr = 12'h300;
        ppu_req = 1; ppu_we = 0; ppu_addr = 12'h108; ppu_lock = 1;
        step();
        chk("lock_rd_gnt", 32'(obs_gnt), 32'b001);
        ppu_we = 1; ppu_wdata = 8'h3C;
        step();
        chk("lock_wr_gnt", 32'(obs_gnt), 32'b001);
        ppu_req = 0; ppu_lock = 0;
        step();
        chk("lock_release_cycle", 32'(obs_gnt), 32'b000);
        step();
        chk("cpu_after_unlock", 32'(obs_gnt), 32'b010);
        cpu_req = 0;
        step();
        chk("rmw_mem", 32'(mem[12'h108]), 32'h3C);

        // Lock timeout with ppu_lock held high
        do_reset();
        cpu_req = 1; cpu_addr = 12'h011;
        ppu_req = 1; ppu_we = 0; ppu_addr = 12'h108; ppu_lock = 1;
        step();
        chk("timeout_entry", 32'(obs_gnt), 32'b001);
        ppu_req = 0;
        k = 0;
        do begin
            step();
            k++;
        end while (obs_gnt != 3'b010 && k < 40);
        chk("timeout_cycles", 32'(k), 32'(LOCK_MAX + 1));
        cpu_addr = 12'h012; ppu_req = 1; ppu_addr = 12'h109;
        step();
        chk("ppu_after_break", 32'(obs_gnt), 32'b001);
        step();
        chk("lock_ignored", 32'(obs_gnt), 32'b010);
        chk("lock_err_sticky", 32'(obs_err), 32'd1);
        idle_inputs();
        step();
        step();
        chk("lock_err_held", 32'(obs_err), 32'd1);

        // Reset arriving mid-lock with a read outstanding
        ppu_req = 1; ppu_addr = 12'h055; ppu_lock = 1; cpu_req = 1; cpu_addr = 12'h066;
        step();
        reset = 1;
        step();
        chk("gnt_in_reset", 32'(obs_gnt), 32'd0);
        reset = 0; ppu_req = 0;
        step();
        chk("cpu_after_reset", 32'(obs_gnt), 32'b010);
        chk("err_cleared", 32'(obs_err), 32'd0);
        idle_inputs();
        step();

        // Random traffic obeying the hold-until-granted handshake
        for (int i = 0; i < 800; i++) begin
            if (!vid_req || m_gnt[2]) begin
                vid_req = ($urandom_range(0, 3) == 0);
                vid_addr = 12'($urandom);
            end
            if (!cpu_req || m_gnt[1]) begin
                cpu_req = ($urandom_range(0, 2) != 0);
                cpu_we = 1'($urandom); cpu_addr = 12'($urandom); cpu_wdata = 8'($urandom);
            end
            if (!ppu_req || m_gnt[0]) begin
                ppu_req = ($urandom_range(0, 2) != 0);
                ppu_we = 1'($urandom); ppu_addr = 12'($urandom); ppu_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 5) == 0) ppu_lock = ~ppu_lock;
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0;
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
